// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// State encodings match what debug tooling expects to see on the state register.
package pc_seq_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        UPD  = 2'b10
    } state_e;

    function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundles the pcreg, instruction-memory, redirect and retire signals of the fetch sequencer.
// The master modport is the sequencer; the slave modport is the surrounding core/memory.
interface pc_fetch_sequencer_if;
    import pc_seq_pkg::*;

    logic            ena;
    logic [PC_W-1:0] pc_cur;
    logic            pc_we;
    logic [PC_W-1:0] pc_next;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_target;
    logic            inst_valid;
    logic [PC_W-1:0] inst_pc;
    logic            misalign_exc;

    modport master (
        input  ena, pc_cur, imem_ack, redirect_valid, redirect_target,
        output pc_we, pc_next, imem_req, imem_addr, inst_valid, inst_pc, misalign_exc
    );

    modport slave (
        output ena, pc_cur, imem_ack, redirect_valid, redirect_target,
        input  pc_we, pc_next, imem_req, imem_addr, inst_valid, inst_pc, misalign_exc
    );

endinterface

// File: rtl/pc_redirect_latch.sv
// Holds the most recent branch/jump target until the next PC write consumes it.
// Selection gives a same-cycle redirect priority over the latched one.
module pc_redirect_latch
    import pc_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            capture_valid,
    input  logic [PC_W-1:0] capture_target,
    input  logic            clear,
    output logic            sel_valid,
    output logic [PC_W-1:0] sel_target
);

    logic            pend_valid_q, pend_valid_d;
    logic [PC_W-1:0] pend_target_q, pend_target_d;

    // Clear beats capture: a redirect arriving with the PC write is consumed by that write.
    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (clear) begin
            pend_valid_d = 1'b0;
        end else if (capture_valid) begin
            pend_valid_d  = 1'b1;
            pend_target_d = capture_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign sel_valid  = capture_valid | pend_valid_q;
    assign sel_target = capture_valid ? capture_target : pend_target_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/PC-update sequencer: requests a fetch at pc_cur, then writes the next PC to pcreg.
// Optional macro PC_ALIGN_CHECK_EN routes misaligned next PCs to EXC_VECTOR and pulses misalign_exc.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0004
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_fetch_sequencer_if.master bus
);

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    state_e          state_q, state_d;
    logic            inst_valid_q, inst_valid_d;
    logic [PC_W-1:0] inst_pc_q, inst_pc_d;

    logic            sel_valid;
    logic [PC_W-1:0] sel_target;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_sel;
    logic            pc_we;
    logic            misaligned;

    pc_redirect_latch u_redirect (
        .clk            (clk),
        .rst            (rst),
        .capture_valid  (bus.redirect_valid),
        .capture_target (bus.redirect_target),
        .clear          (pc_we),
        .sel_valid      (sel_valid),
        .sel_target     (sel_target)
    );

    assign pc_seq = bus.pc_cur + PC_INCR;

    // Any redirect live or pending at the ack cycle squashes that fetch; the handshake still completes.
    always_comb begin
        state_d      = state_q;
        inst_valid_d = 1'b0;
        inst_pc_d    = inst_pc_q;
        pc_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ena) state_d = REQ;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    state_d      = UPD;
                    inst_valid_d = ~sel_valid;
                    inst_pc_d    = bus.pc_cur;
                end
            end
            UPD: begin
                pc_we = bus.ena;
                if (bus.ena) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign pc_sel     = sel_valid ? sel_target : pc_seq;
    assign misaligned = ALIGN_CHK && is_misaligned(pc_sel);

    // pc_next parks at RESET_PC whenever no write is happening.
    assign bus.pc_we        = pc_we;
    assign bus.pc_next      = !pc_we    ? RESET_PC :
                              misaligned ? EXC_VECTOR : pc_sel;
    assign bus.misalign_exc = pc_we & misaligned;
    assign bus.imem_req     = (state_q == REQ);
    assign bus.imem_addr    = (state_q == REQ) ? bus.pc_cur : '0;
    assign bus.inst_valid   = inst_valid_q;
    assign bus.inst_pc      = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios then random traffic against a transaction-level model.
// Honors PC_ALIGN_CHECK_EN the same way as the design build.
module tb_pc_fetch_sequencer;
    import pc_seq_pkg::*;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0004;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] pcreg;

    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // pcreg model
    always @(posedge clk) begin
        if (rst) pcreg <= RESET_PC;
        else if (bus.pc_we) pcreg <= bus.pc_next;
    end
    assign bus.pc_cur = pcreg;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Architectural model: a fetch is outstanding, or a fetched instruction waits to retire.
    bit          fetching, retiring, first_retire, squashed, pend_v;
    logic [31:0] arch_pc, pend_t, fetched_pc;

    function automatic void model_reset();
        fetching     = 1'b0;
        retiring     = 1'b0;
        first_retire = 1'b0;
        squashed     = 1'b0;
        pend_v       = 1'b0;
        pend_t       = '0;
        arch_pc      = RESET_PC;
        fetched_pc   = '0;
    endfunction

    task automatic step(input bit e, input bit ack, input bit rv, input logic [31:0] tgt, input bit r);
        logic [31:0] nxt;
        bit          we, mis, iv;
        @(negedge clk);
        rst                 = r;
        bus.ena             = e;
        bus.imem_ack        = ack;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        #1;
        we  = retiring && e;
        nxt = rv ? tgt : (pend_v ? pend_t : arch_pc + 32'd4);
        mis = ALIGN && (nxt[1:0] != 2'b00);
        if (mis) nxt = EXC_VECTOR;
        iv  = retiring && first_retire && !squashed;
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, fetching});
        if (fetching) chk("imem_addr", bus.imem_addr, arch_pc);
        chk("pc_we", {31'd0, bus.pc_we}, {31'd0, we});
        chk("pc_next", bus.pc_next, we ? nxt : RESET_PC);
        chk("misalign_exc", {31'd0, bus.misalign_exc}, {31'd0, we && mis});
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, iv});
        if (iv) chk("inst_pc", bus.inst_pc, fetched_pc);
        if (r) begin
            model_reset();
        end else begin
            if (retiring) first_retire = 1'b0;
            if (fetching && ack) begin
                squashed     = rv || pend_v;
                fetched_pc   = arch_pc;
                fetching     = 1'b0;
                retiring     = 1'b1;
                first_retire = 1'b1;
            end else if (we) begin
                arch_pc  = nxt;
                retiring = 1'b0;
                fetching = 1'b1;
            end else if (!fetching && !retiring && e) begin
                fetching = 1'b1;
            end
            if (we) pend_v = 1'b0;
            else if (rv) begin
                pend_v = 1'b1;
                pend_t = tgt;
            end
        end
    endtask

    initial begin
        bus.ena             = 1'b0;
        bus.imem_ack        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        step(0, 0, 0, 0, 1);
        chk("rst_pc_next", bus.pc_next, RESET_PC);

        // back-to-back fetches with same-cycle ack
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);  chk("s1_addr0", bus.imem_addr, 32'h0);
        step(1, 1, 0, 0, 0);  chk("s1_inst_pc0", bus.inst_pc, 32'h0);
                              chk("s1_next4", bus.pc_next, 32'h4);

        // delayed ack at 0x4
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            chk("s2_addr_hold", bus.imem_addr, 32'h4);
        end
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);  chk("s2_inst_pc4", bus.inst_pc, 32'h4);
                              chk("s2_inst_valid", {31'd0, bus.inst_valid}, 32'd1);

        // redirect during REQ squashes the fetch at 0x8
        step(1, 0, 1, 32'h100, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);  chk("s3_squash", {31'd0, bus.inst_valid}, 32'd0);
                              chk("s3_next", bus.pc_next, 32'h100);
        step(1, 1, 0, 0, 0);  chk("s3_addr", bus.imem_addr, 32'h100);

        // later redirect overwrites the pending one
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h100, 0);
        step(1, 1, 1, 32'h200, 0);
        step(1, 0, 0, 0, 0);  chk("s4_overwrite", bus.pc_next, 32'h200);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);  chk("s4_cleared", bus.pc_next, 32'h204);

        // wrap at top of address space, with a stall in UPD
        step(1, 1, 1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);  chk("s5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            chk("s5_stall_we", {31'd0, bus.pc_we}, 32'd0);
        end
        step(1, 0, 0, 0, 0);  chk("s5_wrap", bus.pc_next, 32'h0);

        // reset in REQ abandons the request; then a misaligned redirect
        step(1, 0, 0, 0, 0);  chk("s6_req", {31'd0, bus.imem_req}, 32'd1);
        step(1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);  chk("s6_req_drop", {31'd0, bus.imem_req}, 32'd0);
                              chk("s6_pc_next", bus.pc_next, RESET_PC);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h102, 0);
        step(1, 0, 0, 0, 0);  chk("s6_mis_next", bus.pc_next, ALIGN ? EXC_VECTOR : 32'h102);
                              chk("s6_mis_exc", {31'd0, bus.misalign_exc}, {31'd0, ALIGN});

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, t, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
